// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg
//   Shared definitions for the pulse train generator: controller state
//   encoding and the default widths of the timing and count fields.
package pulse_gen_pkg;

  // Default width of the WIDTH/PERIOD timing fields (clock cycles).
  localparam int DEF_CNT_W = 16;
  // Default width of the COUNT field and the SENT counter.
  localparam int DEF_NUM_W = 8;

  // Controller states. The encoding is fixed so that it reads the same
  // in waveforms and in any software that inspects it.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HIGH   = 2'd1,
    LOW    = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/pulse_timer.sv
// pulse_timer
//   Phase timer for pulse_gen. It is a down-counter that is loaded with the
//   length of a phase when the phase is entered. It then counts down while
//   enabled, and flags the last cycle of the phase.
//
// Ports
//   CLK       in   system clock, rising edge
//   RST       in   asynchronous active-high reset
//   load      in   load load_val into the counter (wins over en)
//   load_val  in   phase length in cycles, CNT_W bits
//   en        in   count down this cycle
//   expire    out  current cycle is the last one of the phase
module pulse_timer
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (en && (cnt_reg != '0)) begin
      // Stop at zero so that a zero load cannot wrap around into a long phase.
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  // A phase of N cycles is loaded with N. The counter therefore reads 1
  // during the phase's last cycle.
  assign expire = en && (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/pulse_gen.sv
// pulse_gen
//   Programmable pulse train generator. A START accepted in IDLE captures
//   WIDTH, PERIOD and COUNT. The generator then emits COUNT pulses, or
//   runs without end when COUNT is 0. Each pulse is WIDTH cycles high and
//   is followed by max(PERIOD-WIDTH, 1) cycles low. After the last pulse,
//   DONE strobes for one cycle. ABORT ends the train at once and gives no
//   DONE. All outputs come straight from flops.
//
// Ports
//   CLK     in   system clock, rising edge
//   RST     in   asynchronous active-high reset
//   START   in   request a train (sampled in IDLE only)
//   ABORT   in   stop the running train; beats START in IDLE
//   WIDTH   in   high time per pulse, CNT_W bits
//   PERIOD  in   pulse-to-pulse period, CNT_W bits
//   COUNT   in   number of pulses, NUM_W bits, 0 = continuous
//   PULSE   out  registered pulse output
//   BUSY    out  a train is in progress
//   DONE    out  one-cycle strobe on normal completion
//   SENT    out  pulses completed in the current or last train (wraps)
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int NUM_W = DEF_NUM_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic [CNT_W-1:0] WIDTH,
  input  logic [CNT_W-1:0] PERIOD,
  input  logic [NUM_W-1:0] COUNT,
  output logic             PULSE,
  output logic             BUSY,
  output logic             DONE,
  output logic [NUM_W-1:0] SENT
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] width_reg, width_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic [NUM_W-1:0] count_reg, count_next;
  logic [NUM_W-1:0] sent_reg, sent_next;
  logic             pulse_reg, pulse_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_en;
  logic             tmr_expire;
  logic [CNT_W-1:0] low_len;

  // The low phase fills the rest of the period. It never drops below one
  // cycle, so successive pulses always stay separated.
  assign low_len = (period_reg > width_reg) ? (period_reg - width_reg) : CNT_W'(1);

  pulse_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .expire   (tmr_expire)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg  <= IDLE;
      width_reg  <= '0;
      period_reg <= '0;
      count_reg  <= '0;
      sent_reg   <= '0;
      pulse_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      width_reg  <= width_next;
      period_reg <= period_next;
      count_reg  <= count_next;
      sent_reg   <= sent_next;
      pulse_reg  <= pulse_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    width_next  = width_reg;
    period_next = period_reg;
    count_next  = count_reg;
    sent_next   = sent_reg;
    pulse_next  = pulse_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = width_reg;
    tmr_en      = 1'b0;

    case (state_reg)
      IDLE: begin
        pulse_next = 1'b0;
        busy_next  = 1'b0;
        if (START && !ABORT) begin
          width_next  = WIDTH;
          period_next = PERIOD;
          count_next  = COUNT;
          sent_next   = '0;
          busy_next   = 1'b1;
          // PULSE is a flop, so it is set here to rise on the accepting edge.
          pulse_next  = (WIDTH != '0);
          tmr_load    = 1'b1;
          tmr_val     = WIDTH;
          state_next  = HIGH;
        end
      end

      HIGH: begin
        tmr_en = 1'b1;
        if (ABORT) begin
          pulse_next = 1'b0;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else if (width_reg == '0) begin
          // A zero-width train spends one silent cycle here, then finishes.
          pulse_next = 1'b0;
          done_next  = 1'b1;
          state_next = FINISH;
        end else if (tmr_expire) begin
          pulse_next = 1'b0;
          sent_next  = sent_reg + NUM_W'(1);
          tmr_load   = 1'b1;
          tmr_val    = low_len;
          state_next = LOW;
        end
      end

      LOW: begin
        tmr_en = 1'b1;
        if (ABORT) begin
          pulse_next = 1'b0;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else if (tmr_expire) begin
          if ((count_reg != '0) && (sent_reg == count_reg)) begin
            done_next  = 1'b1;
            state_next = FINISH;
          end else begin
            pulse_next = 1'b1;
            tmr_load   = 1'b1;
            tmr_val    = width_reg;
            state_next = HIGH;
          end
        end
      end

      FINISH: begin
        // DONE is high during this cycle. BUSY drops on the edge that
        // returns the controller to IDLE.
        busy_next  = 1'b0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign PULSE = pulse_reg;
  assign BUSY  = busy_reg;
  assign DONE  = done_reg;
  assign SENT  = sent_reg;

endmodule

// File: tb/tb_pulse_gen.sv
// tb_pulse_gen
//   Scoreboard bench for pulse_gen. The stimulus process pushes the
//   expected outcome of each train, derived from period arithmetic, onto a
//   queue. The monitor pops one entry each time BUSY rises. It then checks
//   the pulse waveform cycle by cycle, the BUSY length, SENT and the DONE
//   timing.
module tb_pulse_gen;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic [15:0] WIDTH = '0;
  logic [15:0] PERIOD = '0;
  logic [7:0]  COUNT = '0;
  logic        PULSE;
  logic        BUSY;
  logic        DONE;
  logic [7:0]  SENT;

  pulse_gen dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .ABORT  (ABORT),
    .WIDTH  (WIDTH),
    .PERIOD (PERIOD),
    .COUNT  (COUNT),
    .PULSE  (PULSE),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .SENT   (SENT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int w;
    int peff;
    int cnt;
    int abort_at;
    int exp_busy;
    int exp_sent;
    int exp_done;
    int by_reset;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   trains_done = 0;
  int   expected_trains = 0;

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s (train %0d): got %0d, want %0d", name, trains_done, got, want);
    end
  endtask

  // Reference model. Each pulse occupies one period of peff = w + low cycles,
  // where low = max(p - w, 1).
  function automatic txn_t make_txn(int w, int p, int c, int j, int rst_flag);
    txn_t t;
    int   l;
    l          = (p > w) ? p - w : 1;
    t.w        = w;
    t.peff     = w + l;
    t.cnt      = c;
    t.abort_at = j;
    t.by_reset = rst_flag;
    if (j > 0) begin
      t.exp_busy = j;
      t.exp_done = 0;
      t.exp_sent = (j - 1 < w) ? 0 : (((j - 1 - w) / t.peff + 1) % 256);
    end else if (w == 0) begin
      t.exp_busy = 2;
      t.exp_done = 1;
      t.exp_sent = 0;
    end else begin
      t.exp_busy = c * t.peff + 1;
      t.exp_done = 1;
      t.exp_sent = c;
    end
    if (rst_flag != 0) begin
      t.exp_busy = 0;
      t.exp_done = 0;
      t.exp_sent = 0;
    end
    return t;
  endfunction

  // Expected PULSE in busy cycle i (i = 1 is the first cycle after acceptance).
  function automatic int exp_pulse(txn_t t, int i);
    if (t.w == 0) return 0;
    if ((t.cnt != 0) && ((i - 1) / t.peff >= t.cnt)) return 0;
    return (((i - 1) % t.peff) < t.w) ? 1 : 0;
  endfunction

  // Monitor
  initial begin : monitor
    txn_t cur;
    int   in_train;
    int   have;
    int   cyc;
    int   wave_bad;
    int   first_bad;
    int   done_cnt;
    int   done_pos;
    in_train = 0;
    have = 0;
    cyc = 0;
    wave_bad = 0;
    first_bad = 0;
    done_cnt = 0;
    done_pos = 0;
    forever begin
      @(negedge CLK);
      if (in_train == 0) begin
        if (BUSY) begin
          in_train  = 1;
          cyc       = 0;
          wave_bad  = 0;
          first_bad = 0;
          done_cnt  = 0;
          done_pos  = 0;
          if (exp_q.size() == 0) begin
            have = 0;
            checks++;
            errors++;
            $display("FAIL unexpected_train: BUSY rose with nothing expected");
          end else begin
            cur  = exp_q.pop_front();
            have = 1;
          end
        end else if (DONE) begin
          checks++;
          errors++;
          $display("FAIL stray_done: DONE=1 while idle, want 0");
        end
      end
      if (in_train != 0) begin
        if (BUSY) begin
          cyc++;
          if (DONE) begin
            done_cnt++;
            done_pos = cyc;
          end
          if ((have != 0) && (int'(PULSE) != exp_pulse(cur, cyc))) begin
            wave_bad++;
            if (first_bad == 0) first_bad = cyc;
          end
        end else begin
          in_train = 0;
          if (have != 0) begin
            if (cur.by_reset == 0) chk("busy_len", cyc, cur.exp_busy);
            if (wave_bad != 0)
              $display("  pulse waveform first differs at busy cycle %0d", first_bad);
            chk("pulse_wave_bad_cycles", wave_bad, 0);
            chk("sent", int'(SENT), cur.exp_sent);
            chk("done_count", done_cnt, cur.exp_done);
            chk("done_pos", done_pos, (cur.exp_done != 0) ? cur.exp_busy : 0);
            chk("pulse_after_idle", int'(PULSE), 0);
            $display("train %0d: w=%0d peff=%0d cnt=%0d abort_at=%0d busy=%0d sent=%0d done=%0d",
                     trains_done, cur.w, cur.peff, cur.cnt, cur.abort_at, cyc, SENT, done_cnt);
          end
          trains_done++;
        end
      end
    end
  end

  task automatic wait_end(int target, int bound);
    int n;
    n = 0;
    while ((trains_done < target) && (n < bound)) begin
      @(negedge CLK);
      #2;
      n++;
    end
    chk("train_completed_in_time", int'(trains_done >= target), 1);
    if (trains_done < target) begin
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      #2;
      exp_q.delete();
      RST = 1'b0;
      expected_trains = trains_done;
    end
  endtask

  task automatic start_train(txn_t t, int w, int p, int c, int scramble);
    @(negedge CLK);
    WIDTH  = 16'(w);
    PERIOD = 16'(p);
    COUNT  = 8'(c);
    START  = 1'b1;
    ABORT  = 1'b0;
    exp_q.push_back(t);
    @(posedge CLK);
    #1;
    chk("start_latency_busy_pulse", int'({BUSY, PULSE}), int'({1'b1, (w != 0)}));
    @(negedge CLK);
    START = 1'b0;
    if (scramble != 0) begin
      // The fields were captured, so later input changes must have no effect.
      WIDTH  = 16'($urandom);
      PERIOD = 16'($urandom);
      COUNT  = 8'($urandom);
    end
  endtask

  task automatic run(int w, int p, int c, int j);
    txn_t t;
    t = make_txn(w, p, c, j, 0);
    start_train(t, w, p, c, 1);
    if (j > 0) begin
      repeat (j - 1) @(negedge CLK);
      ABORT = 1'b1;
    end
    expected_trains++;
    wait_end(expected_trains, t.exp_busy + 20);
    ABORT = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  // Stimulus
  initial begin : stimulus
    txn_t t;
    int   bad;
    int   w;
    int   p;
    int   c;
    int   j;

    repeat (2) @(posedge CLK);
    #1;
    chk("reset_state", int'({PULSE, BUSY, DONE, SENT}), 0);
    RST = 1'b0;

    // Fixed scenarios
    run(10, 25, 3, 0);
    run(260, 1000, 0, 2500);
    run(30, 20, 2, 0);
    run(0, 50, 5, 0);
    run(1, 1, 0, 600);
    run(1, 0, 1, 0);

    // Reset in the middle of a long high phase
    t = make_txn(100, 150, 2, 0, 1);
    start_train(t, 100, 150, 2, 1);
    repeat (40) @(negedge CLK);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("reset_async_pulse_busy", int'({PULSE, BUSY}), 0);
    expected_trains++;
    wait_end(expected_trains, 5);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge CLK);
      if (DONE || BUSY || PULSE) bad++;
    end
    chk("quiet_after_reset", bad, 0);

    // A START right after reset release must be taken on the first edge.
    @(posedge CLK);
    #1;
    RST = 1'b1;
    #2;
    RST = 1'b0;
    run(4, 6, 2, 0);

    // START and ABORT together in IDLE
    @(negedge CLK);
    WIDTH  = 16'd5;
    PERIOD = 16'd8;
    COUNT  = 8'd1;
    START  = 1'b1;
    ABORT  = 1'b1;
    bad = 0;
    repeat (4) begin
      @(posedge CLK);
      #1;
      if (BUSY || PULSE) bad++;
    end
    chk("start_abort_tie_idle", bad, 0);
    @(negedge CLK);
    START = 1'b0;
    ABORT = 1'b0;
    repeat (2) @(negedge CLK);

    // START held high: a second train starts one cycle after IDLE is re-entered.
    t = make_txn(3, 5, 2, 0, 0);
    exp_q.push_back(t);
    start_train(t, 3, 5, 2, 0);
    START = 1'b1;
    expected_trains++;
    wait_end(expected_trains, t.exp_busy + 20);
    @(posedge CLK);
    #1;
    chk("retrigger_busy", int'(BUSY), 1);
    @(negedge CLK);
    START = 1'b0;
    expected_trains++;
    wait_end(expected_trains, t.exp_busy + 20);
    repeat (2) @(negedge CLK);

    // Random trains
    for (int k = 0; k < 12; k++) begin
      p = int'($urandom_range(0, 30));
      if ($urandom_range(0, 2) == 0) begin
        w = int'($urandom_range(1, 12));
        c = 0;
        j = int'($urandom_range(1, 60));
      end else begin
        w = int'($urandom_range(0, 12));
        c = int'($urandom_range(1, 4));
        j = 0;
      end
      run(w, p, c, j);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
